// File: rtl/decrypt_stream.sv
// Streaming XOR/permutation decryptor: two-stage pipeline with valid/ready handshake,
// a rotating runtime-loadable key schedule and a resync pulse for that schedule.
module decrypt_stream #(
  parameter int DATA_W    = 8,
  parameter int NUM_KEYS  = 3,
  parameter int ROT_EVERY = 1,
  parameter int PERM_ROT  = 0,
  parameter logic [NUM_KEYS*DATA_W-1:0] KEY_INIT = '0,
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int CNT_W = (ROT_EVERY > 1) ? $clog2(ROT_EVERY) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  input  logic              key_we,
  input  logic [IDX_W-1:0]  key_addr,
  input  logic [DATA_W-1:0] key_data,
  input  logic              key_sync,
  output logic [IDX_W-1:0]  key_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROT_EVERY - 1);

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[(i + PERM_ROT) % DATA_W] = x[i];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] key_r [NUM_KEYS];
  logic [IDX_W-1:0]  key_idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_din_r;
  logic [DATA_W-1:0] s1_key_r;
  logic [DATA_W-1:0] dout_r;
  logic              dout_valid_r;

  logic              s2_adv_s;
  logic              din_ready_s;
  logic              accept_s;
  logic [IDX_W-1:0]  base_idx_s;
  logic [CNT_W-1:0]  base_cnt_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic [CNT_W-1:0]  next_cnt_s;
  logic [DATA_W-1:0] key_sel_s;

  // Handshake and next key-schedule state; a sync in the accept cycle restarts the period at key 0
  always_comb begin
    s2_adv_s    = !dout_valid_r || dout_ready;
    din_ready_s = !rst && (!s1_valid_r || s2_adv_s);
    accept_s    = din_valid && din_ready_s;
    base_idx_s  = key_sync ? '0 : key_idx_r;
    base_cnt_s  = key_sync ? '0 : cnt_r;
    key_sel_s   = key_r[base_idx_s];
    next_idx_s  = base_idx_s;
    next_cnt_s  = base_cnt_s;
    if (accept_s) begin
      if (base_cnt_s == LAST_CNT) begin
        next_cnt_s = '0;
        next_idx_s = (base_idx_s == LAST_IDX) ? '0 : base_idx_s + IDX_W'(1);
      end else begin
        next_cnt_s = base_cnt_s + CNT_W'(1);
      end
    end else begin
      next_idx_s = base_idx_s;
      next_cnt_s = base_cnt_s;
    end
  end

  // Key registers and rotation state; the accepted beat samples the pre-write key value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        key_r[k] <= KEY_INIT[k*DATA_W +: DATA_W];
      end
      key_idx_r <= '0;
      cnt_r     <= '0;
    end else begin
      if (key_we && (int'(key_addr) < NUM_KEYS)) begin
        key_r[key_addr] <= key_data;
      end
      key_idx_r <= next_idx_s;
      cnt_r     <= next_cnt_s;
    end
  end

  // Two-stage pipeline; dout keeps its last value whenever nothing new is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_din_r     <= '0;
      s1_key_r     <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      if (s2_adv_s) begin
        dout_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          dout_r <= rotl(s1_din_r ^ s1_key_r);
        end
      end
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        s1_din_r   <= din;
        s1_key_r   <= key_sel_s;
      end else if (s2_adv_s) begin
        s1_valid_r <= 1'b0;
      end
    end
  end

  assign din_ready  = din_ready_s;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign key_idx    = key_idx_r;

endmodule

// File: doc/decrypt_stream.md
Name: decrypt_stream

Overview:
Parametrised streaming XOR/permutation decryption engine. It is the next generation of the fixed 8-bit, 3-key, always-enabled decrypt path. It adds:
- configurable data width, key count, key-rotation period and permutation rotate;
- runtime-loadable keys;
- key-schedule resynchronisation;
- a full valid/ready handshake with backpressure.

It sits between the byte/word receive interface and the downstream consumer. It is the inverse of the matching encrypt stream block.

Parameters:
DATA_W, 8, data and key word width in bits (≥2)
NUM_KEYS, 3, number of key registers in the rotation (1..16)
ROT_EVERY, 1, accepted beats per key before advancing to the next key (≥1)
PERM_ROT, 0, output permutation: dout = rotate-left(scrambled, PERM_ROT), 0..DATA_W-1
KEY_INIT, {NUM_KEYS{8'h00}}, reset values of the keys; key k = KEY_INIT[k*DATA_W +: DATA_W]

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
din  in  DATA_W  ciphertext word
din_valid  in  1  din is valid
din_ready  out  1  block can accept din this cycle
dout  out  DATA_W  plaintext word
dout_valid  out  1  dout is valid
dout_ready  in  1  consumer accepts dout this cycle
key_we  in  1  key write strobe
key_addr  in  $clog2(NUM_KEYS) (min 1)  key register index
key_data  in  DATA_W  key write data
key_sync  in  1  pulse: reset the key pointer and the rotation counter
key_idx  out  $clog2(NUM_KEYS) (min 1)  key pointer for the next accepted beat (debug)

Behaviour:
- Reset: one clock; the reset is synchronous and active-high on rst; all state uses clk. While rst is high:
  - dout=0, dout_valid=0, din_ready=0, key_idx=0;
  - rotation counter = 0; key k = KEY_INIT slice k;
  - both pipeline stages empty.
  - din_ready is 1 in the first cycle after rst deasserts.
- Accept rule:
  - An input beat is accepted when din_valid && din_ready.
  - An output beat is transferred when dout_valid && dout_ready.
- Pipeline, 2 stages:
  - S1 registers din together with key[key_idx] sampled at acceptance.
  - S2 registers rotl(S1.din ^ S1.key, PERM_ROT) into dout.
  - Latency with no stall: a beat accepted in cycle N appears on dout with dout_valid=1 in cycle N+2.
  - Throughput: 1 beat per cycle.
- Backpressure:
  - S2 advances when it is empty or dout_ready=1.
  - S1 advances when S2 advances.
  - din_ready = !S1_valid || S2 advances. din_ready is combinational from dout_ready.
  - While dout_valid=1 and dout_ready=0, dout holds stable and at most 2 beats are held; no beat is lost or duplicated.
- Key schedule:
  - The rotation counter increments only on an accepted beat.
  - When the counter reaches ROT_EVERY-1 on an accepted beat, it clears to 0 and key_idx advances. key_idx wraps from NUM_KEYS-1 to 0.
  - key_din is not gated by din_valid alone; a stalled offer does not advance the schedule.
- key_sync:
  - Sets key_idx=0 and counter=0 in the next cycle.
  - If a beat is accepted in the same cycle, that beat uses key 0 and counts as the first beat of the new period, so the next state is counter=1, or key_idx=1 when ROT_EVERY=1.
  - Beats already in S1/S2 are unaffected.
- Key write:
  - key_we writes key_data to key[key_addr] at the clock edge. key_addr ≥ NUM_KEYS is ignored.
  - If a beat is accepted in the same cycle and uses that key, it uses the old value.
  - The new value applies to beats accepted from the next cycle on. Writes are allowed while traffic flows.
- Reset mid-stream: in-flight beats are discarded, dout_valid drops, keys revert to KEY_INIT, and the schedule restarts at key 0.
- No X propagation: dout holds its last value when dout_valid=0.

Test Plan:
1. DATA_W=8, NUM_KEYS=3, ROT_EVERY=1, PERM_ROT=0; write keys 5A,3C,A5; stream din FF,FF,FF,FF with dout_ready=1 -> dout A5,C3,5A,A5 in cycles N+2..N+5, key_idx sequence 0,1,2,0.
2. ROT_EVERY=2, same keys; din 00 ×7 -> dout 5A,5A,3C,3C,A5,A5,5A.
3. PERM_ROT=1, key0=5A; din 5B -> dout 02, because 5B^5A=01 and rotl gives 02.
4. Backpressure: stream 6 beats with dout_ready low for cycles 3-6 -> din_ready falls after 2 beats are held, dout stable while stalled, all 6 outputs correct and in order, and the schedule advances only on accepted beats.
5. key_sync pulsed together with the 3rd accepted beat (keys 5A,3C,A5; din 00) -> outputs 5A,3C,5A,3C; key_we rewrites key1=FF in the same cycle as the beat that uses key1 -> that beat uses 3C and the next key1 use gives FF.
6. Assert rst with 2 beats in flight -> the following cycle has dout_valid=0, dout=00, din_ready=0, key_idx=0; after release, din 00 -> dout KEY_INIT key0.
